hdmi_timing_ctrl: RTL and testbench

- Raster timing generator that sequences the HDMI pixel output register stage.
- Produces horizontal/vertical sync, data enable and pixel coordinates for the pixel colour source.
- Its h_sync, v_sync and data_en outputs drive in_h_sync, in_v_sync and in_data_en of the output register.
- x/y are cycle-aligned with data_en, so a combinational colour source stays aligned through the downstream register.

---
 rtl/hdmi_timing_ctrl.sv | 151 +++++++++++++++
 tb/tb_hdmi_timing_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_ctrl.sv
// Raster timing generator: sync, data enable and pixel coordinates for the HDMI output register stage.
// Latency: one clock from counter position to registered outputs. No backpressure; en low parks the raster at the frame origin.
module hdmi_timing_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        h_sync,
    output logic        v_sync,
    output logic        data_en,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        vblank,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_FP_START   = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_BP_START   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_FP_START   = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_BP_START   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);

    localparam logic HS_ON = (H_SYNC_POL != 0);
    localparam logic VS_ON = (V_SYNC_POL != 0);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    logic [11:0] hc;
    logic [11:0] vc;
    logic [11:0] hc_nxt;
    logic [11:0] vc_nxt;
    phase_t      h_ph;
    phase_t      v_ph;
    phase_t      h_ph_nxt;
    phase_t      v_ph_nxt;
    logic        h_wrap;
    logic        v_wrap;
    logic        at_origin;

    assign h_wrap    = (hc == H_LAST);
    assign v_wrap    = (vc == V_LAST);
    assign at_origin = (hc == 12'd0) && (vc == 12'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc   <= '0;
            vc   <= '0;
            h_ph <= PH_ACTIVE;
            v_ph <= PH_ACTIVE;
        end else begin
            hc   <= hc_nxt;
            vc   <= vc_nxt;
            h_ph <= h_ph_nxt;
            v_ph <= v_ph_nxt;
        end
    end

    // Phase registers track the phase of the counter value they sit beside,
    // so transitions are keyed on the counter value being loaded next.
    always_comb begin
        hc_nxt   = hc;
        vc_nxt   = vc;
        h_ph_nxt = h_ph;
        v_ph_nxt = v_ph;
        if (!en) begin
            hc_nxt   = '0;
            vc_nxt   = '0;
            h_ph_nxt = PH_ACTIVE;
            v_ph_nxt = PH_ACTIVE;
        end else begin
            hc_nxt = h_wrap ? 12'd0 : hc + 12'd1;
            case (h_ph)
                PH_ACTIVE: if (hc_nxt == H_FP_START)   h_ph_nxt = PH_FRONT;
                PH_FRONT:  if (hc_nxt == H_SYNC_START) h_ph_nxt = PH_SYNC;
                PH_SYNC:   if (hc_nxt == H_BP_START)   h_ph_nxt = PH_BACK;
                PH_BACK:   if (h_wrap)                 h_ph_nxt = PH_ACTIVE;
                default:                               h_ph_nxt = PH_ACTIVE;
            endcase
            if (h_wrap) begin
                vc_nxt = v_wrap ? 12'd0 : vc + 12'd1;
                case (v_ph)
                    PH_ACTIVE: if (vc_nxt == V_FP_START)   v_ph_nxt = PH_FRONT;
                    PH_FRONT:  if (vc_nxt == V_SYNC_START) v_ph_nxt = PH_SYNC;
                    PH_SYNC:   if (vc_nxt == V_BP_START)   v_ph_nxt = PH_BACK;
                    PH_BACK:   if (v_wrap)                 v_ph_nxt = PH_ACTIVE;
                    default:                               v_ph_nxt = PH_ACTIVE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_sync      <= ~HS_ON;
            v_sync      <= ~VS_ON;
            data_en     <= 1'b0;
            x           <= '0;
            y           <= '0;
            vblank      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else if (!en) begin
            // Idle outputs; frame_count keeps its value across an aborted frame.
            h_sync      <= ~HS_ON;
            v_sync      <= ~VS_ON;
            data_en     <= 1'b0;
            x           <= '0;
            y           <= '0;
            vblank      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= (h_ph == PH_SYNC) ? HS_ON : ~HS_ON;
            v_sync      <= (v_ph == PH_SYNC) ? VS_ON : ~VS_ON;
            data_en     <= (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
            x           <= hc;
            y           <= vc;
            vblank      <= (v_ph != PH_ACTIVE);
            line_start  <= (hc == 12'd0);
            frame_start <= at_origin;
            if (at_origin) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Bench for hdmi_timing_ctrl: a reference raster model feeds a scoreboard, plus targeted timing checks.
module tb_hdmi_timing_ctrl;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        vb;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // instance 0: default 640x480 timing; instance 1: tiny raster, active-high syncs
    logic        rst_d, en_d, hs_d, vs_d, de_d, vb_d, ls_d, fs_d;
    logic [11:0] x_d, y_d;
    logic [15:0] fc_d;
    logic        rst_s, en_s, hs_s, vs_s, de_s, vb_s, ls_s, fs_s;
    logic [11:0] x_s, y_s;
    logic [15:0] fc_s;
    obs_t        obs_d, obs_s;

    assign obs_d = {hs_d, vs_d, de_d, x_d, y_d, vb_d, ls_d, fs_d, fc_d};
    assign obs_s = {hs_s, vs_s, de_s, x_s, y_s, vb_s, ls_s, fs_s, fc_s};

    hdmi_timing_ctrl dut_d (
        .clk(core_clk), .rst(rst_d), .en(en_d),
        .h_sync(hs_d), .v_sync(vs_d), .data_en(de_d), .x(x_d), .y(y_d),
        .vblank(vb_d), .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
    );

    hdmi_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1)
    ) dut_s (
        .clk(core_clk), .rst(rst_s), .en(en_s),
        .h_sync(hs_s), .v_sync(vs_s), .data_en(de_s), .x(x_s), .y(y_s),
        .vblank(vb_s), .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
    );

    int   hact[2] = '{640, 8};
    int   hfp[2]  = '{16, 2};
    int   hsy[2]  = '{96, 2};
    int   hbp[2]  = '{48, 2};
    int   vact[2] = '{480, 4};
    int   vfp[2]  = '{10, 1};
    int   vsy[2]  = '{2, 1};
    int   vbp[2]  = '{33, 1};
    logic hpol[2] = '{1'b0, 1'b1};
    logic vpol[2] = '{1'b0, 1'b1};

    int          mh[2];
    int          mv[2];
    logic [15:0] mfc[2];
    obs_t        sbq[$];
    obs_t        last;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t idle_obs(input int s);
        obs_t o;
        o    = '0;
        o.hs = ~hpol[s];
        o.vs = ~vpol[s];
        o.fc = mfc[s];
        return o;
    endfunction

    function automatic obs_t decode(input int s);
        obs_t o;
        int   h;
        int   v;
        h    = mh[s];
        v    = mv[s];
        o    = '0;
        o.hs = (h >= hact[s] + hfp[s] && h < hact[s] + hfp[s] + hsy[s]) ? hpol[s] : ~hpol[s];
        o.vs = (v >= vact[s] + vfp[s] && v < vact[s] + vfp[s] + vsy[s]) ? vpol[s] : ~vpol[s];
        o.de = (h < hact[s]) && (v < vact[s]);
        o.x  = 12'(h);
        o.y  = 12'(v);
        o.vb = (v >= vact[s]);
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        return o;
    endfunction

    task automatic advance(input int s);
        int htot;
        int vtot;
        htot = hact[s] + hfp[s] + hsy[s] + hbp[s];
        vtot = vact[s] + vfp[s] + vsy[s] + vbp[s];
        if (mh[s] == htot - 1) begin
            mh[s] = 0;
            mv[s] = (mv[s] == vtot - 1) ? 0 : mv[s] + 1;
        end else begin
            mh[s] = mh[s] + 1;
        end
    endtask

    // Drive one clock of en, queue the model's expectation, then compare after the edge.
    task automatic cycle(input int s, input logic e);
        obs_t exp;
        obs_t got;
        if (s == 0) en_d = e;
        else        en_s = e;
        if (e) begin
            exp = decode(s);
            if (exp.fs) mfc[s] = mfc[s] + 16'd1;
            exp.fc = mfc[s];
            advance(s);
        end else begin
            mh[s] = 0;
            mv[s] = 0;
            exp   = idle_obs(s);
        end
        sbq.push_back(exp);
        @(posedge core_clk);
        #1;
        got = (s == 0) ? obs_d : obs_s;
        exp = sbq.pop_front();
        chk("cycle", got, exp);
        last = got;
    endtask

    task automatic do_reset(input int s);
        if (s == 0) begin rst_d = 1'b1; en_d = 1'b0; end
        else        begin rst_s = 1'b1; en_s = 1'b0; end
        mh[s]  = 0;
        mv[s]  = 0;
        mfc[s] = '0;
        repeat (2) @(posedge core_clk);
        #1;
        chk("reset_state", (s == 0) ? obs_d : obs_s, idle_obs(s));
        if (s == 0) rst_d = 1'b0;
        else        rst_s = 1'b0;
    endtask

    initial begin
        int de_cnt, de_last, hs_cnt, hs_first, ls_prev, ls_per;
        int vs_cnt, vs_first, vb_cnt, vb_first_y, fs_prev, fs_per;
        rst_d = 1'b1; en_d = 1'b0;
        rst_s = 1'b1; en_s = 1'b0;

        // default timing: first edge, one full line, async reset at (700,1)
        do_reset(0);
        de_cnt = 0; de_last = -1; hs_cnt = 0; hs_first = -1; ls_prev = -1; ls_per = 0;
        for (int i = 0; i < 1501; i++) begin
            cycle(0, 1'b1);
            if (i == 0) begin
                chk("t1_de", last.de, 1);
                chk("t1_fs", last.fs, 1);
                chk("t1_fc", last.fc, 1);
                chk("t1_hs", last.hs, 1);
                chk("t1_vs", last.vs, 1);
            end
            if (last.y == 0) begin
                if (last.de) begin de_cnt++; de_last = int'(last.x); end
                if (!last.hs) begin
                    if (hs_cnt == 0) hs_first = int'(last.x);
                    hs_cnt++;
                end
            end
            if (last.ls) begin
                if (ls_prev >= 0) ls_per = i - ls_prev;
                ls_prev = i;
            end
        end
        chk("t2_de_cnt", de_cnt, 640);
        chk("t2_de_last_x", de_last, 639);
        chk("t2_hs_first_x", hs_first, 656);
        chk("t2_hs_cnt", hs_cnt, 96);
        chk("t2_ls_period", ls_per, 800);
        chk("t5_pos", {last.x, last.y}, {12'd700, 12'd1});
        #2 rst_d = 1'b1;
        #1;
        chk("t5_async_hs", hs_d, 1);
        chk("t5_async_vs", vs_d, 1);
        chk("t5_async_de", de_d, 0);
        chk("t5_async_fc", fc_d, 0);
        rst_d = 1'b1; en_d = 1'b0;

        // tiny raster: 14-clock lines, 98-clock frames
        do_reset(1);
        hs_cnt = 0; hs_first = -1; ls_prev = -1; ls_per = 0;
        vs_cnt = 0; vs_first = -1; vb_cnt = 0; vb_first_y = -1; fs_prev = -1; fs_per = 0;
        for (int i = 0; i < 197; i++) begin
            cycle(1, 1'b1);
            if (last.y == 0 && i < 14 && last.hs) begin
                if (hs_cnt == 0) hs_first = int'(last.x);
                hs_cnt++;
            end
            if (last.ls) begin
                if (ls_prev >= 0) ls_per = i - ls_prev;
                ls_prev = i;
            end
            if (i < 98 && last.vs) begin
                if (vs_cnt == 0) vs_first = i;
                vs_cnt++;
            end
            if (i < 98 && last.vb) begin
                if (vb_cnt == 0) vb_first_y = int'(last.y);
                vb_cnt++;
            end
            if (last.fs) begin
                if (fs_prev >= 0) fs_per = i - fs_prev;
                fs_prev = i;
            end
            if (i == 98) chk("t3_fc_frame2", last.fc, 2);
        end
        chk("t6_hs_first_x", hs_first, 10);
        chk("t6_hs_cnt", hs_cnt, 2);
        chk("t6_ls_period", ls_per, 14);
        chk("t3_vs_first_cyc", vs_first, 70);
        chk("t3_vs_cnt", vs_cnt, 14);
        chk("t3_vb_first_y", vb_first_y, 4);
        chk("t3_vb_cnt", vb_cnt, 42);
        chk("t6_frame_period", fs_per, 98);

        // en dropped mid-frame, then re-enabled
        do_reset(1);
        for (int i = 0; i < 34; i++) cycle(1, 1'b1);
        chk("t4_pos", {last.x, last.y}, {12'd5, 12'd2});
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1'b0);
            chk("t4_idle_de", last.de, 0);
            chk("t4_idle_fc", last.fc, 1);
        end
        cycle(1, 1'b1);
        chk("t4_restart_xy", {last.x, last.y}, 24'd0);
        chk("t4_restart_fs", last.fs, 1);
        chk("t4_restart_fc", last.fc, 2);

        // async reset inside the v_sync line
        for (int i = 0; i < 82; i++) cycle(1, 1'b1);
        chk("t5s_pos", {last.x, last.y, last.vs}, {12'd12, 12'd5, 1'b1});
        #2 rst_s = 1'b1;
        #1;
        chk("t5s_async_hs", hs_s, 0);
        chk("t5s_async_vs", vs_s, 0);
        chk("t5s_async_de", de_s, 0);
        chk("t5s_async_fc", fc_s, 0);
        @(posedge core_clk);
        #1;
        chk("t5s_hold_idle", {de_s, fs_s, ls_s, x_s, y_s}, 27'd0);
        rst_s  = 1'b0;
        mh[1]  = 0;
        mv[1]  = 0;
        mfc[1] = '0;

        // frame_count wrap
        cycle(1, 1'b1);
        chk("t6_fc_after_rst", last.fc, 1);
        force dut_s.frame_count = 16'hFFFF;
        #1;
        release dut_s.frame_count;
        mfc[1] = 16'hFFFF;
        for (int i = 0; i < 98; i++) cycle(1, 1'b1);
        chk("t6_wrap_fs", last.fs, 1);
        chk("t6_wrap_fc", last.fc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
